// File: rtl/stack_ctrl_if.sv
// Control-unit side handshake of the operand stack sequencer.
// master: control unit (drives requests and push data).
// slave : stack_ctrl (returns data, completion and status).
interface stack_ctrl_if #(
  parameter int DW = 8
);
  logic          push;
  logic          pop;
  logic          tos;
  logic [DW-1:0] din;
  logic [DW-1:0] dout;
  logic          done;
  logic          busy;
  logic          full;
  logic          empty;
  logic          err;

  modport master (
    output push, pop, tos, din,
    input  dout, done, busy, full, empty, err
  );

  modport slave (
    input  push, pop, tos, din,
    output dout, done, busy, full, empty, err
  );
endinterface

// File: rtl/stack_ctrl.sv
// Operand stack sequencer for the stack multicycle processor.
// The top element lives in top_q; the remaining elements are spilled to
// and refilled from a single-port synchronous-read RAM (element 0 = bottom).
// Optional build macro STACK_ERR_STICKY_EN: err stays high from the first
// illegal request until reset instead of pulsing with done.
module stack_ctrl #(
  parameter int DW    = 8,
  parameter int DEPTH = 16,
  parameter int AW    = 4
) (
  input  logic          clk,
  input  logic          rst,
  stack_ctrl_if.slave   bus,
  output logic [AW-1:0] ram_addr,
  output logic [DW-1:0] ram_wdata,
  output logic          ram_we,
  output logic          ram_re,
  input  logic [DW-1:0] ram_rdata
);

  localparam logic [AW:0] DEPTH_C = (AW+1)'(DEPTH);

  typedef enum logic [1:0] {
    IDLE,
    POP_RD,
    POP_WAIT
  } state_t;

  state_t        state;
  logic [AW:0]   count;
  logic [DW-1:0] top_q;
  logic [DW-1:0] dout_q;
  logic          done_q;
  logic          busy_q;
  logic          err_q;
  // Set once all requests have been seen low in IDLE; a level request held
  // through its own done cycle must not start a second operation.
  logic          armed;

  logic any_req;
  logic multi_req;

  // Request decode
  always_comb begin
    any_req   = bus.push | bus.pop | bus.tos;
    multi_req = (bus.push & bus.pop) | (bus.push & bus.tos) | (bus.pop & bus.tos);
  end

  // Main sequencer: request acceptance, stack bookkeeping, RAM strobes
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      count     <= '0;
      top_q     <= '0;
      dout_q    <= '0;
      done_q    <= 1'b0;
      busy_q    <= 1'b0;
      err_q     <= 1'b0;
      armed     <= 1'b1;
      ram_addr  <= '0;
      ram_wdata <= '0;
      ram_we    <= 1'b0;
      ram_re    <= 1'b0;
    end else begin
      done_q <= 1'b0;
      ram_we <= 1'b0;
      ram_re <= 1'b0;
`ifndef STACK_ERR_STICKY_EN
      err_q  <= 1'b0;
`endif
      case (state)
        IDLE: begin
          if (armed && any_req) begin
            armed <= 1'b0;
            if (multi_req) begin
              err_q  <= 1'b1;
              done_q <= 1'b1;
            end else if (bus.push) begin
              done_q <= 1'b1;
              if (count == DEPTH_C) begin
                err_q <= 1'b1;
              end else if (count == '0) begin
                top_q <= bus.din;
                count <= (AW+1)'(1);
              end else begin
                // Spill current top to RAM while loading the new top.
                ram_we    <= 1'b1;
                ram_addr  <= AW'(count - 1'b1);
                ram_wdata <= top_q;
                top_q     <= bus.din;
                count     <= count + 1'b1;
              end
            end else if (bus.pop) begin
              if (count == '0) begin
                err_q  <= 1'b1;
                done_q <= 1'b1;
              end else if (count == (AW+1)'(1)) begin
                dout_q <= top_q;
                count  <= '0;
                done_q <= 1'b1;
              end else begin
                // Return the top now; refill it from RAM two cycles later.
                dout_q   <= top_q;
                ram_re   <= 1'b1;
                ram_addr <= AW'(count - (AW+1)'(2));
                busy_q   <= 1'b1;
                state    <= POP_RD;
              end
            end else begin
              done_q <= 1'b1;
              if (count == '0) begin
                err_q <= 1'b1;
              end else begin
                dout_q <= top_q;
              end
            end
          end else if (!any_req) begin
            armed <= 1'b1;
          end
        end

        POP_RD: begin
          state <= POP_WAIT;
        end

        POP_WAIT: begin
          top_q  <= ram_rdata;
          count  <= count - 1'b1;
          done_q <= 1'b1;
          busy_q <= 1'b0;
          state  <= IDLE;
        end

        default: begin
          state  <= IDLE;
          busy_q <= 1'b0;
        end
      endcase
    end
  end

  // Status outputs
  always_comb begin
    bus.dout  = dout_q;
    bus.done  = done_q;
    bus.busy  = busy_q;
    bus.err   = err_q;
    bus.full  = (count == DEPTH_C);
    bus.empty = (count == '0);
  end

endmodule
